// File: rtl/nhit_window_ctrl_if.sv
// -----------------------------------------------------------------------------
// nhit_window_ctrl_if
//
// Event/trigger bundle between the NHIT window controller and the readout
// logic that consumes its event records.
//
//   trig         1       one-cycle trigger pulse (threshold met)
//   evt_nhit     NHIT_W  hit count of the buffered event
//   evt_valid    1       event buffer holds an unread record
//   evt_ready    1       consumer accepts the buffered record
//   evt_dropped  16      saturating count of events lost to a full buffer
//
// Modports:
//   master  - the controller (drives the event, samples evt_ready)
//   slave   - the consumer  (reads the event, drives evt_ready)
// -----------------------------------------------------------------------------
interface nhit_window_ctrl_if #(
    parameter int NHIT_W = 8
);
    logic              trig;
    logic [NHIT_W-1:0] evt_nhit;
    logic              evt_valid;
    logic              evt_ready;
    logic [15:0]       evt_dropped;

    modport master (
        output trig,
        output evt_nhit,
        output evt_valid,
        output evt_dropped,
        input  evt_ready
    );

    modport slave (
        input  trig,
        input  evt_nhit,
        input  evt_valid,
        input  evt_dropped,
        output evt_ready
    );
endinterface

// File: rtl/nhit_window_ctrl.sv
// -----------------------------------------------------------------------------
// nhit_window_ctrl
//
// Sequencer for the NHIT latch/popcount datapath. Waits for the first PMT hit,
// lets a fixed coincidence window elapse, samples the hit count, raises a
// trigger when the count reaches the threshold, stores an event record, then
// drives the shared latch-clear line for CLR_CYCLES followed by a HOLDOFF
// dead time before re-arming.
//
// Parameters:
//   NHIT_W      width of hit count and threshold
//   WINDOW      coincidence window in clk cycles (>=1)
//   CLR_CYCLES  cycles pmt_clear is held high (>=1)
//   HOLDOFF     dead cycles after the clear before re-arm (>=1)
//   DN_PERIOD   dark-noise snapshot period in cycles (only with the macro)
//
// Ports:
//   clk, rst_n  clock; asynchronous active-low reset
//   enable      arms the controller, looked at only while idle
//   threshold   trigger threshold, 0 disables triggering
//   nhit_in     popcount from the datapath (asynchronous to clk)
//   pmt_clear   drives the datapath latch 'interrupt' line
//   dn_snap     one-cycle dark-noise snapshot strobe
//   evt         event/trigger bundle (master side)
//
// Optional feature: define NHIT_DN_SCHED_EN to schedule periodic dark-noise
// snapshots on the clear line. Without it dn_snap is tied low and no period
// logic exists.
// -----------------------------------------------------------------------------
module nhit_window_ctrl #(
    parameter int NHIT_W     = 8,
    parameter int WINDOW     = 16,
    parameter int CLR_CYCLES = 2,
    parameter int HOLDOFF    = 8,
    parameter int DN_PERIOD  = 1000000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [NHIT_W-1:0]     threshold,
    input  logic [NHIT_W-1:0]     nhit_in,
    output logic                  pmt_clear,
    output logic                  dn_snap,
    nhit_window_ctrl_if.master    evt
);

    if (WINDOW < 1 || CLR_CYCLES < 1 || HOLDOFF < 1 || DN_PERIOD < 1) begin : g_param_check
        $error("nhit_window_ctrl: WINDOW, CLR_CYCLES, HOLDOFF and DN_PERIOD must all be >= 1");
    end

    // One down-counter serves every timed state, so it is sized for the
    // longest of the three intervals.
    localparam int CNT_MAX = (WINDOW > CLR_CYCLES)
                           ? ((WINDOW > HOLDOFF) ? WINDOW : HOLDOFF)
                           : ((CLR_CYCLES > HOLDOFF) ? CLR_CYCLES : HOLDOFF);
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] WIN_LOAD  = CNT_W'(WINDOW - 1);
    localparam logic [CNT_W-1:0] CLR_LOAD  = CNT_W'(CLR_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLDOFF - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WINDOW,
        ST_SAMPLE,
        ST_CLEAR,
        ST_HOLDOFF
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sample_en;
    logic               hit_qual;
    logic               dn_pend;

    logic [NHIT_W-1:0]  nhit_meta, nhit_s;

    logic               pmt_clear_q;
    logic               trig_q;
    logic               evt_valid_q;
    logic [NHIT_W-1:0]  evt_nhit_q;
    logic [15:0]        evt_dropped_q;

    // ------------------------------------------------------------------
    // Two-flop synchronizer. The popcount bus is multi-bit, so individual
    // samples may be incoherent; that is tolerated because the value is only
    // tested for nonzero while idle and captured after the window settled.
    // ------------------------------------------------------------------
    // NOTE: every clocked block uses non-blocking assignments so all flops
    // see the pre-edge values, whatever order the blocks are evaluated in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nhit_meta <= '0;
            nhit_s    <= '0;
        end else begin
            nhit_meta <= nhit_in;
            nhit_s    <= nhit_meta;
        end
    end

    assign hit_qual = enable && (nhit_s != '0);

    // ------------------------------------------------------------------
    // Optional dark-noise scheduler: a free-running period counter raises a
    // pending request; the request is served from IDLE only when no hit
    // qualifies that cycle, so real events always take precedence.
    // ------------------------------------------------------------------
`ifdef NHIT_DN_SCHED_EN
    localparam int DN_W = (DN_PERIOD > 1) ? $clog2(DN_PERIOD) : 1;

    logic [DN_W-1:0] dn_cnt_q;
    logic            dn_pend_q;
    logic            dn_snap_q;
    logic            dn_tick;
    logic            dn_fire;

    assign dn_tick = (dn_cnt_q == DN_W'(DN_PERIOD - 1));
    assign dn_fire = (state_q == ST_IDLE) && dn_pend_q && !hit_qual;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dn_cnt_q  <= '0;
            dn_pend_q <= 1'b0;
            dn_snap_q <= 1'b0;
        end else begin
            dn_cnt_q  <= dn_tick ? '0 : dn_cnt_q + DN_W'(1);
            // A new period tick wins over a same-cycle service so no
            // request is ever lost.
            if (dn_tick)      dn_pend_q <= 1'b1;
            else if (dn_fire) dn_pend_q <= 1'b0;
            dn_snap_q <= dn_fire;
        end
    end

    assign dn_pend = dn_pend_q;
    assign dn_snap = dn_snap_q;
`else
    assign dn_pend = 1'b0;
    assign dn_snap = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Sequencer state register. Reset lands in CLEAR so the latches are
    // wiped after every reset before the first window can open.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_CLEAR;
            cnt_q   <= CLR_LOAD;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path through
    // the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sample_en = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (hit_qual) begin
                    state_d = ST_WINDOW;
                    cnt_d   = WIN_LOAD;
                end else if (dn_pend) begin
                    // Snapshot: clear the latches without trigger or event.
                    state_d = ST_CLEAR;
                    cnt_d   = CLR_LOAD;
                end
            end
            ST_WINDOW: begin
                if (cnt_q == '0) state_d = ST_SAMPLE;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            ST_SAMPLE: begin
                sample_en = 1'b1;
                state_d   = ST_CLEAR;
                cnt_d     = CLR_LOAD;
            end
            ST_CLEAR: begin
                if (cnt_q == '0) begin
                    state_d = ST_HOLDOFF;
                    cnt_d   = HOLD_LOAD;
                end else begin
                    cnt_d   = cnt_q - CNT_W'(1);
                end
            end
            ST_HOLDOFF: begin
                if (cnt_q == '0) state_d = ST_IDLE;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            default: begin
                state_d = ST_CLEAR;
                cnt_d   = CLR_LOAD;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registered outputs. pmt_clear follows the next state so it is a clean
    // flop output (it drives an asynchronous line) yet still rises on the
    // same edge the FSM enters CLEAR; its reset value of 1 makes it assert
    // asynchronously with rst_n.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pmt_clear_q   <= 1'b1;
            trig_q        <= 1'b0;
            evt_valid_q   <= 1'b0;
            evt_nhit_q    <= '0;
            evt_dropped_q <= '0;
        end else begin
            pmt_clear_q <= (state_d == ST_CLEAR);
            trig_q      <= sample_en && (threshold != '0) && (nhit_s >= threshold);

            if (sample_en && (!evt_valid_q || evt.evt_ready)) begin
                // A load overrides a same-cycle handshake: the consumer took
                // the old record and the new one replaces it.
                evt_nhit_q  <= nhit_s;
                evt_valid_q <= 1'b1;
            end else begin
                if (sample_en && (evt_dropped_q != 16'hFFFF)) begin
                    evt_dropped_q <= evt_dropped_q + 16'd1;
                end
                if (evt_valid_q && evt.evt_ready) begin
                    evt_valid_q <= 1'b0;
                end
            end
        end
    end

    assign pmt_clear       = pmt_clear_q;
    assign evt.trig        = trig_q;
    assign evt.evt_nhit    = evt_nhit_q;
    assign evt.evt_valid   = evt_valid_q;
    assign evt.evt_dropped = evt_dropped_q;

endmodule
